// File: rtl/irq_collector.sv
// ============================================================================
// Module   : irq_collector
// Purpose  : Interrupt concentrator. Synchronises up to 32 peripheral irq
//            lines, latches each one as rising-edge or level sensitive, and
//            combines the masked pending bits into one registered CPU irq.
//            RAW / MASK / PENDING / EDGE_CFG are reachable over a simple
//            chip-select slave bus.
// Ports    : clk          - system clock, rising edge
//            reset_n      - asynchronous active-low reset
//            irq_in       - N_IRQ raw interrupt lines (may be asynchronous)
//            irq          - combined interrupt to CPU (registered)
//            s_cs_n       - slave chip select, active low
//            s_address    - word address (0 RAW, 1 MASK, 2 PENDING, 3 EDGE_CFG)
//            s_read       - read strobe, qualified by ~s_cs_n
//            s_readdata   - registered read data, held until the next read
//            s_write      - write strobe, qualified by ~s_cs_n
//            s_writedata  - write data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_collector #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_IRQ-1:0] irq_in,
    output logic             irq,
    input  logic             s_cs_n,
    input  logic [1:0]       s_address,
    input  logic             s_read,
    output logic [31:0]      s_readdata,
    input  logic             s_write,
    input  logic [31:0]      s_writedata
);

    localparam logic [1:0] ADDR_RAW      = 2'd0;
    localparam logic [1:0] ADDR_MASK     = 2'd1;
    localparam logic [1:0] ADDR_PENDING  = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CFG = 2'd3;

    logic [N_IRQ-1:0] sync1;
    logic [N_IRQ-1:0] sync;
    logic [N_IRQ-1:0] prev;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] edge_cfg;

    logic [N_IRQ-1:0] pending_next;
    logic [N_IRQ-1:0] edge_set;
    logic [N_IRQ-1:0] w1c;
    logic [N_IRQ-1:0] wdata;
    logic [31:0]      rd_word;

    logic rd_en;
    logic wr_en;
    logic wr_mask;
    logic wr_pending;
    logic wr_edge_cfg;

    // Upper write-data bits beyond N_IRQ are intentionally discarded.
    logic unused_wdata;
    assign unused_wdata = ^s_writedata;

    assign rd_en       = ~s_cs_n & s_read;
    assign wr_en       = ~s_cs_n & s_write;
    assign wr_mask     = wr_en & (s_address == ADDR_MASK);
    assign wr_pending  = wr_en & (s_address == ADDR_PENDING);
    assign wr_edge_cfg = wr_en & (s_address == ADDR_EDGE_CFG);
    assign wdata       = s_writedata[N_IRQ-1:0];

    // Rising edge seen on the synchronised line.
    assign edge_set = sync & ~prev;

    // W1C only touches edge-mode bits; level bits simply mirror the line.
    assign w1c = wr_pending ? (wdata & edge_cfg) : '0;

    // Edge bits: set beats clear in the same cycle, otherwise hold.
    // Level bits load sync1, i.e. the value sync takes at this same edge, so
    // pending always equals sync in level mode (two-edge input latency).
    // The mode used here is the current edge_cfg, so an EDGE_CFG write only
    // changes behaviour from the following cycle.
    assign pending_next = (edge_cfg & ((pending & ~w1c) | edge_set))
                        | (~edge_cfg & sync1);

    always_comb begin
        rd_word = '0;
        case (s_address)
            ADDR_RAW:      rd_word[N_IRQ-1:0] = sync;
            ADDR_MASK:     rd_word[N_IRQ-1:0] = mask;
            ADDR_PENDING:  rd_word[N_IRQ-1:0] = pending;
            ADDR_EDGE_CFG: rd_word[N_IRQ-1:0] = edge_cfg;
            default:       rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync       <= '0;
            prev       <= '0;
            pending    <= '0;
            mask       <= '0;
            edge_cfg   <= '0;
            irq        <= 1'b0;
            s_readdata <= '0;
        end else begin
            sync1   <= irq_in;
            sync    <= sync1;
            prev    <= sync;
            pending <= pending_next;
            // irq reflects register values from before this edge, giving the
            // one-cycle pending->irq and two-cycle MASK-write->irq latencies.
            irq     <= |(pending & mask);
            if (wr_mask) begin
                mask <= wdata;
            end
            if (wr_edge_cfg) begin
                edge_cfg <= wdata;
            end
            // Read samples pre-edge values, so a same-cycle write is not seen.
            if (rd_en) begin
                s_readdata <= rd_word;
            end
        end
    end

endmodule

`default_nettype wire
